// File: rtl/pseudo_analog_ramp.sv
// rtl/pseudo_analog_ramp.sv - D-pad to centred analog position emulator with per-axis ramp
// Each axis keeps a signed deflection, a step multiplier and its last direction; all update on TICK.
module pseudo_analog_ramp #(
    parameter int AXES      = 2,
    parameter int W         = 8,
    parameter int STEP      = 15,
    parameter int CSTEP     = 15,
    parameter int ACCEL_MAX = 3,
    parameter int LIMIT     = 120,
    parameter int CENTER    = 127
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                TICK,
    input  logic [AXES-1:0]     POS,
    input  logic [AXES-1:0]     NEG,
    input  logic [2*AXES-1:0]   MODE,
    output logic [AXES*W-1:0]   OUT,
    output logic                UPD
);
    localparam int DW = W + 2;
    localparam int MW = (ACCEL_MAX < 2) ? 2 : $clog2(ACCEL_MAX + 1);
    localparam int M_RESTART = (ACCEL_MAX < 2) ? ACCEL_MAX : 2;

    localparam logic [1:0] DIR_NONE  = 2'd0;
    localparam logic [1:0] DIR_POS   = 2'd1;
    localparam logic [1:0] DIR_NEG   = 2'd2;
    localparam logic [1:0] MODE_HOLD = 2'd1;
    localparam logic [1:0] MODE_SNAP = 2'd2;

    logic r_upd;

    genvar gi;
    generate
        for (gi = 0; gi < AXES; gi++) begin : g_axis
            logic signed [DW-1:0] r_d;
            logic [MW-1:0]        r_m;
            logic [1:0]           r_dir;
            logic [W-1:0]         r_out;

            logic [1:0]           w_dir;
            logic [1:0]           w_mode;
            logic signed [31:0]   w_d;
            logic signed [31:0]   w_delta;
            logic signed [31:0]   w_sum;
            logic signed [31:0]   w_next_d;
            logic [MW-1:0]        w_next_m;

            // 32-bit signed working arithmetic so d +/- delta never wraps before the clamp
            always_comb begin
                w_mode = MODE[2*gi +: 2];
                if (POS[gi] && !NEG[gi]) begin
                    w_dir = DIR_POS;
                end else if (NEG[gi] && !POS[gi]) begin
                    w_dir = DIR_NEG;
                end else begin
                    w_dir = DIR_NONE;
                end
                w_d      = 32'(r_d);
                w_delta  = 32'sd0;
                w_sum    = w_d;
                w_next_d = w_d;
                w_next_m = MW'(1);

                if (w_mode == MODE_SNAP) begin
                    case (w_dir)
                        DIR_POS: w_next_d = LIMIT;
                        DIR_NEG: w_next_d = -LIMIT;
                        default: w_next_d = 32'sd0;
                    endcase
                end else if (w_dir == DIR_NONE) begin
                    if (w_mode != MODE_HOLD) begin
                        if (w_d > CSTEP) begin
                            w_next_d = w_d - CSTEP;
                        end else if (w_d < -CSTEP) begin
                            w_next_d = w_d + CSTEP;
                        end else begin
                            w_next_d = 32'sd0;
                        end
                    end
                end else begin
                    if (w_dir == r_dir) begin
                        w_delta  = STEP * int'(r_m);
                        w_next_m = (int'(r_m) >= ACCEL_MAX) ? MW'(ACCEL_MAX) : r_m + MW'(1);
                    end else begin
                        w_delta  = STEP;
                        w_next_m = MW'(M_RESTART);
                    end
                    w_sum = (w_dir == DIR_POS) ? (w_d + w_delta) : (w_d - w_delta);
                    if (w_sum > LIMIT) begin
                        w_next_d = LIMIT;
                    end else if (w_sum < -LIMIT) begin
                        w_next_d = -LIMIT;
                    end else begin
                        w_next_d = w_sum;
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_d   <= '0;
                    r_m   <= MW'(1);
                    r_dir <= DIR_NONE;
                    r_out <= W'(CENTER);
                end else if (TICK) begin
                    r_d   <= DW'(w_next_d);
                    r_m   <= w_next_m;
                    r_dir <= w_dir;
                    r_out <= W'(CENTER + w_next_d);
                end
            end

            assign OUT[gi*W +: W] = r_out;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_upd <= 1'b0;
        end else begin
            r_upd <= TICK;
        end
    end

    assign UPD = r_upd;

endmodule

// File: tb/tb_pseudo_analog_ramp.sv
// tb/tb_pseudo_analog_ramp.sv - vector table, centring sequence and randomized model check
module tb_pseudo_analog_ramp;
    localparam int AXES      = 2;
    localparam int W         = 8;
    localparam int STEP      = 15;
    localparam int CSTEP     = 15;
    localparam int CSTEP2    = 20;
    localparam int ACCEL_MAX = 3;
    localparam int LIMIT     = 120;
    localparam int CENTER    = 127;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, tick, upd;
    logic [1:0]  pos, neg;
    logic [3:0]  mode;
    logic [15:0] out;
    logic        rst2, tick2, upd2;
    logic [1:0]  pos2, neg2;
    logic [3:0]  mode2;
    logic [15:0] out2;

    pseudo_analog_ramp dut (
        .CLK(clk), .RESET(rst), .TICK(tick), .POS(pos), .NEG(neg),
        .MODE(mode), .OUT(out), .UPD(upd)
    );

    pseudo_analog_ramp #(.CSTEP(CSTEP2)) dut2 (
        .CLK(clk), .RESET(rst2), .TICK(tick2), .POS(pos2), .NEG(neg2),
        .MODE(mode2), .OUT(out2), .UPD(upd2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit         rst;
        bit         tick;
        logic [1:0] pos;
        logic [1:0] neg;
        logic [3:0] mode;
        int         e0;
        int         e1;
        bit         eupd;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input bit r, input bit t, input logic [1:0] p, input logic [1:0] n,
                                input logic [3:0] m, input int e0, input int e1, input bit eu);
        vec_t v;
        v.rst = r; v.tick = t; v.pos = p; v.neg = n; v.mode = m;
        v.e0 = e0; v.e1 = e1; v.eupd = eu;
        vt.push_back(v);
    endfunction

    // Reference model: deflection as a plain integer, direction as -1/0/+1
    int m_d[AXES];
    int m_m[AXES];
    int m_dir[AXES];
    bit m_upd;

    function automatic void model_step(input bit r, input bit t, input logic [1:0] p,
                                       input logic [1:0] n, input logic [3:0] m);
        if (r) begin
            for (int a = 0; a < AXES; a++) begin
                m_d[a] = 0; m_m[a] = 1; m_dir[a] = 0;
            end
            m_upd = 1'b0;
        end else begin
            m_upd = t;
            if (t) begin
                for (int a = 0; a < AXES; a++) begin
                    int dir;
                    int md;
                    int delta;
                    int mag;
                    int sgn;
                    dir = (p[a] && !n[a]) ? 1 : ((n[a] && !p[a]) ? -1 : 0);
                    md  = int'(m[2*a +: 2]);
                    if (md == 2) begin
                        m_d[a] = dir * LIMIT;
                        m_m[a] = 1;
                    end else if (dir == 0) begin
                        if (md != 1) begin
                            sgn = (m_d[a] < 0) ? -1 : 1;
                            mag = (m_d[a] < 0) ? -m_d[a] : m_d[a];
                            mag = (mag > CSTEP) ? mag - CSTEP : 0;
                            m_d[a] = sgn * mag;
                        end
                        m_m[a] = 1;
                    end else begin
                        if (dir == m_dir[a]) begin
                            delta  = STEP * m_m[a];
                            m_m[a] = (m_m[a] + 1 > ACCEL_MAX) ? ACCEL_MAX : m_m[a] + 1;
                        end else begin
                            delta  = STEP;
                            m_m[a] = (ACCEL_MAX < 2) ? ACCEL_MAX : 2;
                        end
                        m_d[a] = m_d[a] + dir * delta;
                        if (m_d[a] > LIMIT)  m_d[a] = LIMIT;
                        if (m_d[a] < -LIMIT) m_d[a] = -LIMIT;
                    end
                    m_dir[a] = dir;
                end
            end
        end
    endfunction

    task automatic cycle(input bit r, input bit t, input logic [1:0] p, input logic [1:0] n,
                         input logic [3:0] m);
        @(negedge clk);
        rst = r; tick = t; pos = p; neg = n; mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle2(input bit r, input bit t, input logic [1:0] p, input logic [1:0] n);
        @(negedge clk);
        rst2 = r; tick2 = t; pos2 = p; neg2 = n; mode2 = 4'h0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rp, rn;
        logic [3:0] rm;
        bit         rr, rt;

        rst = 1'b1; tick = 1'b0; pos = 2'b00; neg = 2'b00; mode = 4'h0;
        rst2 = 1'b1; tick2 = 1'b0; pos2 = 2'b00; neg2 = 2'b00; mode2 = 4'h0;

        // reset dominates tick, then an empty tick still pulses UPD
        add(1, 1, 2'b11, 2'b00, 4'h0, 127, 127, 0);
        add(0, 0, 2'b00, 2'b00, 4'h0, 127, 127, 0);
        add(0, 1, 2'b00, 2'b00, 4'h0, 127, 127, 1);
        add(0, 0, 2'b00, 2'b00, 4'h0, 127, 127, 0);
        // acceleration and clamp on axis0; POS without TICK is frozen
        add(0, 1, 2'b01, 2'b00, 4'h0, 142, 127, 1);
        add(0, 0, 2'b01, 2'b00, 4'h0, 142, 127, 0);
        add(0, 1, 2'b01, 2'b00, 4'h0, 172, 127, 1);
        add(0, 1, 2'b01, 2'b00, 4'h0, 217, 127, 1);
        add(0, 1, 2'b01, 2'b00, 4'h0, 247, 127, 1);
        // hold mode keeps the clamp value, then reversal restarts the ramp
        for (int k = 0; k < 5; k++) add(0, 1, 2'b00, 2'b00, 4'h1, 247, 127, 1);
        add(0, 1, 2'b00, 2'b01, 4'h1, 232, 127, 1);
        add(0, 1, 2'b00, 2'b01, 4'h1, 202, 127, 1);
        // snap on axis1, both-pressed decodes as none
        add(0, 1, 2'b10, 2'b00, 4'h9, 202, 247, 1);
        add(0, 1, 2'b00, 2'b10, 4'h9, 202,   7, 1);
        add(0, 1, 2'b10, 2'b10, 4'h9, 202, 127, 1);
        add(0, 1, 2'b00, 2'b00, 4'h9, 202, 127, 1);
        // mode change without TICK retains d; the next TICK centres from there
        add(0, 1, 2'b10, 2'b00, 4'h9, 202, 247, 1);
        add(0, 0, 2'b00, 2'b00, 4'h0, 202, 247, 0);
        add(0, 1, 2'b00, 2'b00, 4'h0, 187, 232, 1);
        // mid-ramp reset, then consecutive ticks
        add(1, 0, 2'b00, 2'b00, 4'h0, 127, 127, 0);
        add(0, 1, 2'b01, 2'b00, 4'h0, 142, 127, 1);
        add(0, 1, 2'b01, 2'b00, 4'h0, 172, 127, 1);
        add(0, 1, 2'b01, 2'b00, 4'h0, 217, 127, 1);
        add(1, 1, 2'b01, 2'b00, 4'h0, 127, 127, 0);
        add(0, 1, 2'b01, 2'b00, 4'h0, 142, 127, 1);
        add(0, 1, 2'b01, 2'b00, 4'h0, 172, 127, 1);
        add(0, 1, 2'b01, 2'b00, 4'h0, 217, 127, 1);
        add(0, 0, 2'b01, 2'b00, 4'h0, 217, 127, 0);

        foreach (vt[i]) begin
            cycle(vt[i].rst, vt[i].tick, vt[i].pos, vt[i].neg, vt[i].mode);
            check($sformatf("vec%0d out0", i), int'(out[7:0]),  vt[i].e0);
            check($sformatf("vec%0d out1", i), int'(out[15:8]), vt[i].e1);
            check($sformatf("vec%0d upd", i),  int'(upd),       int'(vt[i].eupd));
        end

        // centring without overshoot with CSTEP=20
        cycle2(1, 0, 2'b00, 2'b00);
        check("c20 reset", int'(out2[7:0]), 127);
        cycle2(0, 1, 2'b01, 2'b00);
        check("c20 ramp1", int'(out2[7:0]), 142);
        cycle2(0, 1, 2'b01, 2'b00);
        check("c20 ramp2", int'(out2[7:0]), 172);
        cycle2(0, 1, 2'b00, 2'b00);
        check("c20 rel1", int'(out2[7:0]), 152);
        cycle2(0, 1, 2'b00, 2'b00);
        check("c20 rel2", int'(out2[7:0]), 132);
        cycle2(0, 1, 2'b00, 2'b00);
        check("c20 rel3", int'(out2[7:0]), 127);
        cycle2(0, 1, 2'b00, 2'b00);
        check("c20 rel4", int'(out2[7:0]), 127);
        check("c20 axis1", int'(out2[15:8]), 127);
        check("c20 upd", int'(upd2), 1);

        // randomized run against the reference model
        cycle(1, 0, 2'b00, 2'b00, 4'h0);
        model_step(1, 0, 2'b00, 2'b00, 4'h0);
        rp = 2'b00; rn = 2'b00; rm = 4'h0;
        for (int c = 0; c < 3000; c++) begin
            rr = ($urandom_range(0, 149) == 0);
            rt = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) rp = 2'($urandom);
            if ($urandom_range(0, 3) == 0) rn = 2'($urandom);
            if ($urandom_range(0, 15) == 0) rm = 4'($urandom);
            cycle(rr, rt, rp, rn, rm);
            model_step(rr, rt, rp, rn, rm);
            check($sformatf("rnd%0d out0", c), int'(out[7:0]),  CENTER + m_d[0]);
            check($sformatf("rnd%0d out1", c), int'(out[15:8]), CENTER + m_d[1]);
            check($sformatf("rnd%0d upd", c),  int'(upd),       int'(m_upd));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
